// File: rtl/mc_seq_pkg.sv
// Shared types for the multi-cycle sequencer: FSM states, trap causes and
// the width helper for the memory wait timer.
package mc_seq_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StMem     = 3'd4,
        StWb      = 3'd5,
        StHalt    = 3'd6,
        StTrap    = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CauseNone    = 2'd0,
        CauseIllegal = 2'd1,
        CauseIbus    = 2'd2,
        CauseDbus    = 2'd3
    } trap_cause_e;

    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been held without a response.
// expire_o flags the last permitted held cycle (the MEM_TIMEOUT-th one).
module mem_wait_timer
    import mc_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TIMER_W     = timer_width(MEM_TIMEOUT)
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expire_o
);

    localparam logic [TIMER_W-1:0] LastCnt = TIMER_W'(MEM_TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Registered-only output keeps the FSM's next-state logic free of a comb loop.
    assign expire_o = (cnt_q == LastCnt);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory handshakes,
// bus timeout, illegal-instruction trap and retired-instruction counter.
module multicycle_sequencer
    import mc_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  run,
    output logic                  imem_req,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] ir,
    input  logic                  dec_memread,
    input  logic                  dec_memwrite,
    input  logic                  dec_regwrite,
    input  logic                  dec_illegal,
    input  logic                  dec_halt,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] mdr,
    output logic                  pc_write,
    output logic                  regwrite,
    output logic [2:0]            state,
    output logic                  halted,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [CNT_WIDTH-1:0]  instret
);

    localparam int unsigned TIMER_W = timer_width(MEM_TIMEOUT);

    state_e                state_q, state_d;
    trap_cause_e           cause_q, cause_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;
    logic                  timer_en;
    logic                  timer_expire;

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_write = 1'b0;
        regwrite = 1'b0;
        timer_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end else if (timer_expire) begin
                    state_d = StTrap;
                    cause_d = CauseIbus;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StDecode: begin
                // A load that is also a store is treated as an illegal encoding.
                if (dec_illegal || (dec_memread && dec_memwrite)) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else if (dec_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                if (dec_memread || dec_memwrite) begin
                    state_d = StMem;
                end else if (dec_regwrite) begin
                    state_d = StWb;
                end else begin
                    pc_write = 1'b1;
                    state_d  = StFetch;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = dec_memwrite;
                if (dmem_rvalid) begin
                    if (dec_memwrite) begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = StWb;
                    end
                end else if (timer_expire) begin
                    state_d = StTrap;
                    cause_d = CauseDbus;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StWb: begin
                regwrite = 1'b1;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            StHalt, StTrap: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign instret_d = pc_write ? instret_q + 1'b1 : instret_q;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TIMER_W     (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .arst_n   (arst_n),
        .clr_i    (state_d != state_q),
        .cnt_en_i (timer_en),
        .expire_o (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q   <= StIdle;
            cause_q   <= CauseNone;
            ir_q      <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    assign ir         = ir_q;
    assign mdr        = mdr_q;
    assign state      = state_q;
    assign halted     = (state_q == StHalt);
    assign trap       = (state_q == StTrap);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: acts as instruction/data memory and decoder, predicts
// per-instruction latency, handshakes and architectural results.
module tb_multicycle_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned MT = 4;

    localparam int KAluNowb = 0;
    localparam int KAluWb   = 1;
    localparam int KLoad    = 2;
    localparam int KStore   = 3;
    localparam int KIllegal = 4;
    localparam int KHalt    = 5;
    localparam int KBoth    = 6;

    localparam logic [2:0] SIdle  = 3'd0;
    localparam logic [2:0] SFetch = 3'd1;
    localparam logic [2:0] SHalt  = 3'd6;
    localparam logic [2:0] STrap  = 3'd7;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          run = 1'b0;
    logic          imem_req;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic [DW-1:0] ir;
    logic          dec_memread = 1'b0;
    logic          dec_memwrite = 1'b0;
    logic          dec_regwrite = 1'b0;
    logic          dec_illegal = 1'b0;
    logic          dec_halt = 1'b0;
    logic          dmem_req;
    logic          dmem_we;
    logic          dmem_rvalid = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic [DW-1:0] mdr;
    logic          pc_write;
    logic          regwrite;
    logic [2:0]    state;
    logic          halted;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    int            checks = 0;
    int            errors = 0;
    int            exp_ret;
    logic [DW-1:0] exp_ir;
    logic [DW-1:0] exp_mdr;
    int            n;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .DATA_WIDTH  (DW),
        .CNT_WIDTH   (CW),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .run          (run),
        .imem_req     (imem_req),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .dec_memread  (dec_memread),
        .dec_memwrite (dec_memwrite),
        .dec_regwrite (dec_regwrite),
        .dec_illegal  (dec_illegal),
        .dec_halt     (dec_halt),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .mdr          (mdr),
        .pc_write     (pc_write),
        .regwrite     (regwrite),
        .state        (state),
        .halted       (halted),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_start();
        arst_n      = 1'b0;
        run         = 1'b0;
        imem_rvalid = 1'b0;
        dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("rst_ctl", {imem_req, dmem_req, dmem_we, pc_write, regwrite, halted, trap,
                        trap_cause, state, instret}, 64'd0);
        chk("rst_ir_mdr", {ir, mdr}, 64'd0);
        arst_n      = 1'b1;
        imem_rvalid = 1'b1;
        dmem_rvalid = 1'b1;
        imem_rdata  = $urandom;
        dmem_rdata  = $urandom;
        @(posedge clk); #1;
        chk("idle_state", state, SIdle);
        chk("idle_ir_mdr", {ir, mdr}, 64'd0);
        run         = 1'b1;
        imem_rvalid = 1'b0;
        dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("run_fetch", state, SFetch);
        exp_ret = 0;
        exp_ir  = '0;
        exp_mdr = '0;
    endtask

    // iw/dw: wait cycles before the response; >= MT means no response in time.
    task automatic run_instr(input int kind, input int iw, input int dw, input logic [DW-1:0] ld);
        logic [DW-1:0] instr;
        int mem, wb, ibus, dbus, ill, hlt, retire;
        int exp_cyc, exp_ireq, exp_dreq, exp_cause;
        int cyc, ireq_n, dreq_n, pcw_n, rw_n, rw_alone, we_bad, done, bad;
        logic [2:0] term;
        instr  = $urandom;
        mem    = (kind == KLoad || kind == KStore) ? 1 : 0;
        wb     = (kind == KAluWb || kind == KLoad) ? 1 : 0;
        ibus   = (iw >= int'(MT)) ? 1 : 0;
        ill    = (!ibus && (kind == KIllegal || kind == KBoth)) ? 1 : 0;
        hlt    = (!ibus && kind == KHalt) ? 1 : 0;
        dbus   = (!ibus && mem && dw >= int'(MT)) ? 1 : 0;
        retire = (ibus || dbus || ill || hlt) ? 0 : 1;

        if (ibus) exp_cyc = MT + 1;
        else if (ill || hlt) exp_cyc = iw + 3;
        else if (dbus) exp_cyc = iw + 3 + MT + 1;
        else exp_cyc = iw + 3 + (mem ? dw + 1 : 0) + wb;
        exp_ireq  = ibus ? MT : iw + 1;
        exp_dreq  = (!mem || ibus) ? 0 : (dbus ? MT : dw + 1);
        exp_cause = ibus ? 2 : (dbus ? 3 : (ill ? 1 : 0));

        dec_memread  = (kind == KLoad || kind == KBoth);
        dec_memwrite = (kind == KStore || kind == KBoth);
        dec_regwrite = (wb != 0);
        dec_illegal  = (kind == KIllegal);
        dec_halt     = (kind == KHalt) || ((kind == KIllegal || kind == KBoth) && $urandom_range(0, 1) == 1);

        cyc = 0; ireq_n = 0; dreq_n = 0; pcw_n = 0; rw_n = 0; rw_alone = 0; we_bad = 0; done = 0;
        while (!done && cyc < 64) begin
            cyc++;
            imem_rvalid = imem_req ? (ireq_n == iw) : 1'($urandom);
            imem_rdata  = (imem_req && ireq_n == iw) ? instr : $urandom;
            dmem_rvalid = dmem_req ? (dreq_n == dw) : 1'($urandom);
            dmem_rdata  = (dmem_req && dreq_n == dw) ? ld : $urandom;
            #1;
            if (imem_req) ireq_n++;
            if (dmem_req) begin
                dreq_n++;
                if (dmem_we !== (kind == KStore)) we_bad++;
            end
            if (pc_write) begin
                pcw_n++;
                done = 1;
            end
            if (regwrite) begin
                rw_n++;
                if (!pc_write) rw_alone++;
            end
            if (trap || halted) done = 1;
            @(posedge clk); #1;
        end

        if (retire) exp_ret = (exp_ret + 1) % (1 << CW);
        if (!ibus) exp_ir = instr;
        if (retire && kind == KLoad) exp_mdr = ld;

        chk("cycles", cyc, exp_cyc);
        chk("imem_req_cycles", ireq_n, exp_ireq);
        chk("dmem_req_cycles", dreq_n, exp_dreq);
        chk("dmem_we", we_bad, 0);
        chk("pc_write_count", pcw_n, retire);
        chk("regwrite_count", rw_n, retire && wb);
        chk("regwrite_without_pc_write", rw_alone, 0);
        chk("ir", ir, exp_ir);
        chk("mdr", mdr, exp_mdr);
        chk("instret", instret, exp_ret);
        chk("trap", trap, ibus || dbus || ill);
        chk("halted", halted, hlt);
        chk("trap_cause", trap_cause, exp_cause);

        if (retire) begin
            chk("back_in_fetch", state, SFetch);
        end else begin
            term = hlt ? SHalt : STrap;
            bad  = 0;
            for (int i = 0; i < 3; i++) begin
                imem_rvalid = 1'($urandom);
                dmem_rvalid = 1'($urandom);
                imem_rdata  = $urandom;
                dmem_rdata  = $urandom;
                #1;
                if (imem_req || dmem_req || pc_write || regwrite || state !== term) bad++;
                @(posedge clk); #1;
            end
            chk("sticky", bad, 0);
            chk("sticky_ir_mdr_instret", {ir, mdr}, {exp_ir, exp_mdr});
            chk("sticky_instret", instret, exp_ret);
            reset_start();
        end
    endtask

    initial begin
        reset_start();

        run_instr(KAluWb, 0, 0, '0);
        run_instr(KLoad, 0, 3, 32'hDEAD_BEEF);
        run_instr(KStore, 1, 0, '0);
        run_instr(KAluNowb, 3, 0, '0);
        run_instr(KAluNowb, 4, 0, '0);
        run_instr(KIllegal, 0, 0, '0);
        run_instr(KHalt, 2, 0, '0);
        run_instr(KBoth, 1, 0, '0);
        run_instr(KLoad, 0, 4, 32'h0BAD_F00D);
        run_instr(KStore, 2, 4, '0);

        for (int i = 0; i < 16; i++) begin
            run_instr((i % 2 == 1) ? KAluNowb : KStore, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom);
        end
        chk("instret_wrap", instret, 0);

        for (int i = 0; i < 60; i++) begin
            run_instr($urandom_range(0, 6),
                      ($urandom_range(0, 9) == 0) ? MT : $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? MT : $urandom_range(0, 3),
                      $urandom);
        end

        // Reset while a load is waiting on the data bus.
        dec_memread  = 1'b1;
        dec_memwrite = 1'b0;
        dec_regwrite = 1'b1;
        dec_illegal  = 1'b0;
        dec_halt     = 1'b0;
        imem_rvalid  = 1'b1;
        imem_rdata   = $urandom;
        dmem_rvalid  = 1'b0;
        n = 0;
        while (!dmem_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("load_mem_entry", n, 3);
        @(posedge clk); #1;
        chk("mem_wait_req", {dmem_req, dmem_we}, 2'b10);
        reset_start();
        run_instr(KLoad, 0, 0, 32'h1357_9BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
